// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner arbitration for one shared open-drain I2C bus, with an
// idle guard gap between owners and a watchdog that revokes stuck grants.
module i2c_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned GUARD_CYCLES   = 64,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] scl_oe_in,
    input  logic [NUM_REQ-1:0] sda_oe_in,
    output logic [NUM_REQ-1:0] grant,
    output logic               scl_oe,
    output logic               sda_oe,
    output logic               busy,
    output logic [NUM_REQ-1:0] timeout_err,
    input  logic [NUM_REQ-1:0] err_clr
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] lockout;
    logic [IW-1:0]      last_owner;
    logic [WW-1:0]      wdog;
    logic [GW-1:0]      guard;

    logic [NUM_REQ-1:0] eligible;
    logic               win_valid;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      cand;

    // Scan starts just past the previous owner so every requester gets a turn.
    always_comb begin
        eligible  = req & ~lockout;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((32'(last_owner) + k) % NUM_REQ);
            if (!win_valid && eligible[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= '0;
            lockout     <= '0;
            last_owner  <= IW'(NUM_REQ - 1);
            wdog        <= '0;
            guard       <= '0;
        end else begin
            lockout     <= lockout & req;
            timeout_err <= timeout_err & ~err_clr;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant      <= NUM_REQ'(1) << win_idx;
                        last_owner <= win_idx;
                        wdog       <= '0;
                        busy       <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    // A dropped request wins over a watchdog expiry in the same cycle.
                    if (!req[last_owner]) begin
                        grant  <= '0;
                        scl_oe <= 1'b0;
                        sda_oe <= 1'b0;
                        guard  <= '0;
                        state  <= GUARD;
                    end else if (wdog == WDOG_LAST) begin
                        grant       <= '0;
                        scl_oe      <= 1'b0;
                        sda_oe      <= 1'b0;
                        guard       <= '0;
                        timeout_err <= (timeout_err & ~err_clr) | grant;
                        lockout     <= (lockout & req) | grant;
                        state       <= GUARD;
                    end else begin
                        scl_oe <= scl_oe_in[last_owner];
                        sda_oe <= sda_oe_in[last_owner];
                        wdog   <= wdog + 1'b1;
                    end
                end
                GUARD: begin
                    if (guard == GUARD_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        guard <= guard + 1'b1;
                    end
                end
                default: begin
                    grant  <= '0;
                    scl_oe <= 1'b0;
                    sda_oe <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scenario bench for i2c_bus_arbiter: expected grants are queued when requests
// are driven and popped when the arbiter issues a grant.
module tb_i2c_bus_arbiter;

    localparam int unsigned N = 3;
    localparam int unsigned G = 8;
    localparam int unsigned T = 100;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] scl_oe_in = '0;
    logic [N-1:0] sda_oe_in = '0;
    logic [N-1:0] err_clr = '0;
    logic [N-1:0] grant;
    logic [N-1:0] timeout_err;
    logic         scl_oe;
    logic         sda_oe;
    logic         busy;

    int unsigned  total = 0;
    int unsigned  bad = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .NUM_REQ(N),
        .GUARD_CYCLES(G),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .scl_oe_in(scl_oe_in),
        .sda_oe_in(sda_oe_in),
        .grant(grant),
        .scl_oe(scl_oe),
        .sda_oe(sda_oe),
        .busy(busy),
        .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; scl_oe_in = '0; sda_oe_in = '0; err_clr = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Ticks until a grant appears; also notes any pad drive while ungranted.
    task automatic wait_grant(input int unsigned limit, output int unsigned cycles,
                              output logic ok, output logic released);
        cycles = 0; released = 1'b1;
        while (grant === '0 && cycles < limit) begin
            tick();
            cycles++;
            if (grant === '0 && (scl_oe !== 1'b0 || sda_oe !== 1'b0)) released = 1'b0;
        end
        ok = (grant !== '0);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '1; scl_oe_in = '1; sda_oe_in = '1;
        tick(); tick();
        total++; if (grant !== '0) begin bad++; $display("FAIL rst_grant got=%b want=000", grant); end
        total++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b%b want=00", scl_oe, sda_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (timeout_err !== '0) begin bad++; $display("FAIL rst_err got=%b want=000", timeout_err); end
        reset = 1'b0; req = '0; scl_oe_in = '0; sda_oe_in = '0;
        exp_q.delete();
    endtask

    task automatic test_basic();
        logic [N-1:0] exp;
        logic         all_busy;
        req = 3'b001; exp_q.push_back(3'b001);
        tick();
        exp = exp_q.pop_front();
        total++; if (grant !== exp) begin bad++; $display("FAIL basic_grant got=%b want=%b", grant, exp); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        scl_oe_in = 3'b010;
        tick(); tick();
        total++; if (scl_oe !== 1'b0) begin bad++; $display("FAIL basic_nonowner_oe got=%b want=0", scl_oe); end
        scl_oe_in = 3'b011;
        tick();
        total++; if (scl_oe !== 1'b1) begin bad++; $display("FAIL basic_scl_oe got=%b want=1", scl_oe); end
        sda_oe_in = 3'b001;
        tick();
        total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL basic_sda_oe got=%b want=1", sda_oe); end
        req = '0;
        tick();
        total++; if (grant !== '0 || scl_oe !== 1'b0 || sda_oe !== 1'b0)
            begin bad++; $display("FAIL basic_release got=%b/%b%b want=000/00", grant, scl_oe, sda_oe); end
        scl_oe_in = '0; sda_oe_in = '0;
        all_busy = busy;
        for (int unsigned i = 0; i < G - 1; i++) begin
            tick();
            if (busy !== 1'b1) all_busy = 1'b0;
        end
        total++; if (all_busy !== 1'b1) begin bad++; $display("FAIL basic_guard_busy got=0 want=1"); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%b want=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        logic [N-1:0] cur;
        int unsigned  cyc;
        logic         ok;
        logic         rel;
        do_reset();
        scl_oe_in = '1; sda_oe_in = '1;
        req = 3'b111;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010);
        exp_q.push_back(3'b100); exp_q.push_back(3'b001);
        for (int r = 0; r < 4; r++) begin
            wait_grant(200, cyc, ok, rel);
            total++; if (!ok) begin bad++; $display("FAIL rr_wait got=none want=grant round=%0d", r); break; end
            if (r > 0) begin
                total++; if (cyc != G + 1) begin bad++; $display("FAIL rr_gap got=%0d want=%0d", cyc, G + 1); end
                total++; if (rel !== 1'b1) begin bad++; $display("FAIL rr_gap_released got=driven want=released"); end
            end
            exp = exp_q.pop_front();
            total++; if (grant !== exp) begin bad++; $display("FAIL rr_grant got=%b want=%b", grant, exp); end
            cur = grant;
            repeat (10) tick();
            total++; if (grant !== cur || scl_oe !== 1'b1)
                begin bad++; $display("FAIL rr_hold got=%b/%b want=%b/1", grant, scl_oe, cur); end
            req = req & ~cur;
            tick();
            total++; if (grant !== '0 || scl_oe !== 1'b0 || sda_oe !== 1'b0)
                begin bad++; $display("FAIL rr_fall got=%b/%b%b want=000/00", grant, scl_oe, sda_oe); end
            if (r < 3) req = req | cur;
        end
        req = '0; scl_oe_in = '0; sda_oe_in = '0;
        repeat (G + 2) tick();
    endtask

    task automatic test_guard_wait();
        logic [N-1:0] exp;
        logic         no_grant;
        logic         all_busy;
        do_reset();
        req = 3'b010; exp_q.push_back(3'b010);
        tick();
        exp = exp_q.pop_front();
        total++; if (grant !== exp) begin bad++; $display("FAIL gw_first got=%b want=%b", grant, exp); end
        repeat (5) tick();
        req = 3'b100; exp_q.push_back(3'b100);
        tick();
        total++; if (grant !== '0) begin bad++; $display("FAIL gw_fall got=%b want=000", grant); end
        no_grant = 1'b1; all_busy = 1'b1;
        for (int unsigned i = 0; i < G; i++) begin
            tick();
            if (grant !== '0) no_grant = 1'b0;
            if (i < G - 1 && busy !== 1'b1) all_busy = 1'b0;
        end
        total++; if (no_grant !== 1'b1) begin bad++; $display("FAIL gw_no_grant_in_guard got=granted want=none"); end
        total++; if (all_busy !== 1'b1) begin bad++; $display("FAIL gw_busy_in_guard got=0 want=1"); end
        tick();
        exp = exp_q.pop_front();
        total++; if (grant !== exp) begin bad++; $display("FAIL gw_second got=%b want=%b", grant, exp); end
        req = '0;
        tick();
        all_busy = busy;
        for (int unsigned i = 0; i < G - 1; i++) begin
            tick();
            if (busy !== 1'b1) all_busy = 1'b0;
        end
        total++; if (all_busy !== 1'b1) begin bad++; $display("FAIL gw_busy_hold got=0 want=1"); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gw_busy_fall got=%b want=0", busy); end
    endtask

    task automatic test_timeout();
        logic [N-1:0] exp;
        int unsigned  cnt;
        int unsigned  cyc;
        logic         ok;
        logic         rel;
        logic         no_grant;
        do_reset();
        req = 3'b001; exp_q.push_back(3'b001);
        tick();
        exp = exp_q.pop_front();
        total++; if (grant !== exp) begin bad++; $display("FAIL to_grant got=%b want=%b", grant, exp); end
        req = 3'b011;
        cnt = 0;
        while (grant !== '0 && cnt < 300) begin tick(); cnt++; end
        total++; if (cnt != T) begin bad++; $display("FAIL to_length got=%0d want=%0d", cnt, T); end
        total++; if (timeout_err !== 3'b001) begin bad++; $display("FAIL to_err got=%b want=001", timeout_err); end
        exp_q.push_back(3'b010);
        wait_grant(50, cyc, ok, rel);
        exp = exp_q.pop_front();
        total++; if (grant !== exp || cyc != G + 1)
            begin bad++; $display("FAIL to_next got=%b@%0d want=%b@%0d", grant, cyc, exp, G + 1); end
        repeat (3) tick();
        req = 3'b001;
        tick();
        no_grant = 1'b1;
        repeat (G + 6) begin
            tick();
            if (grant !== '0) no_grant = 1'b0;
        end
        total++; if (no_grant !== 1'b1) begin bad++; $display("FAIL to_lockout got=%b want=000", grant); end
        req = 3'b000;
        tick();
        req = 3'b001; exp_q.push_back(3'b001);
        tick();
        exp = exp_q.pop_front();
        total++; if (grant !== exp) begin bad++; $display("FAIL to_regrant got=%b want=%b", grant, exp); end
        total++; if (timeout_err !== 3'b001) begin bad++; $display("FAIL to_sticky got=%b want=001", timeout_err); end
        err_clr = 3'b001;
        tick();
        err_clr = '0;
        total++; if (timeout_err !== '0) begin bad++; $display("FAIL to_clear got=%b want=000", timeout_err); end
        err_clr = 3'b010;
        tick();
        err_clr = '0;
        total++; if (timeout_err !== '0) begin bad++; $display("FAIL to_clear_idle_bit got=%b want=000", timeout_err); end
        err_clr = 3'b001;
        cnt = 0;
        while (grant !== '0 && cnt < 300) begin tick(); cnt++; end
        err_clr = '0;
        total++; if (timeout_err !== 3'b001) begin bad++; $display("FAIL to_set_priority got=%b want=001", timeout_err); end
        req = '0;
        repeat (G + 2) tick();
    endtask

    task automatic test_timeout_edge();
        logic [N-1:0] exp;
        int unsigned  cyc;
        logic         ok;
        logic         rel;
        do_reset();
        req = 3'b001; exp_q.push_back(3'b001);
        tick();
        exp = exp_q.pop_front();
        total++; if (grant !== exp) begin bad++; $display("FAIL te_grant got=%b want=%b", grant, exp); end
        repeat (T - 1) tick();
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL te_hold got=%b want=001", grant); end
        req = '0;
        tick();
        total++; if (grant !== '0 || timeout_err !== '0)
            begin bad++; $display("FAIL te_release got=%b/%b want=000/000", grant, timeout_err); end
        req = 3'b001; exp_q.push_back(3'b001);
        wait_grant(50, cyc, ok, rel);
        exp = exp_q.pop_front();
        total++; if (grant !== exp || cyc != G + 1)
            begin bad++; $display("FAIL te_regrant got=%b@%0d want=%b@%0d", grant, cyc, exp, G + 1); end
        req = '0;
        repeat (G + 2) tick();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] exp;
        do_reset();
        req = 3'b100; exp_q.push_back(3'b100);
        tick();
        exp = exp_q.pop_front();
        total++; if (grant !== exp) begin bad++; $display("FAIL rm_grant got=%b want=%b", grant, exp); end
        sda_oe_in = 3'b100;
        tick();
        total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rm_sda got=%b want=1", sda_oe); end
        reset = 1'b1;
        tick();
        total++; if (sda_oe !== 1'b0 || grant !== '0 || busy !== 1'b0)
            begin bad++; $display("FAIL rm_release got=%b/%b/%b want=0/000/0", sda_oe, grant, busy); end
        reset = 1'b0; sda_oe_in = '0;
        req = 3'b111; exp_q.push_back(3'b001);
        tick();
        exp = exp_q.pop_front();
        total++; if (grant !== exp) begin bad++; $display("FAIL rm_first got=%b want=%b", grant, exp); end
        req = '0;
        repeat (G + 2) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_guard_wait();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
